neighbor_stream_rx: RTL and testbench

Edge-PE-side receiver for the neighbor-list stream emitted by each neighbor bank controller. Filters the broadcast stream by PE tag, unpacks each two-ID beat into individual neighbor IDs, and buffers them in a small FIFO. Presents the IDs to the Edge PE datapath over a valid/ready handshake with a per-list `last` marker. Exports a free-space credit so the neighbor memory controller issues a new request only when a full list fits.

---
 rtl/neighbor_stream_rx_pkg.sv | 31 +++
 rtl/nid_fifo2w.sv | 42 ++++
 rtl/neighbor_stream_rx.sv | 113 +++++++++++
 tb/tb_neighbor_stream_rx.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/neighbor_stream_rx_pkg.sv
// Shared types and system constants for the Edge-PE neighbor-list stream.
package neighbor_stream_rx_pkg;

    localparam int unsigned Neighbor_info_bandwidth = 16;
    localparam int unsigned max_degree_Iter         = 8;
    localparam int unsigned Num_Edge_PE             = 4;

    localparam int unsigned NID_W = Neighbor_info_bandwidth / 2;
    localparam int unsigned CNT_W = $clog2(max_degree_Iter) + 1;
    localparam int unsigned TAG_W = $clog2(Num_Edge_PE);

    typedef struct packed {
        logic                               valid;
        logic                               sos;
        logic                               eos;
        logic [Neighbor_info_bandwidth-1:0] FV_data;
        logic [TAG_W-1:0]                   PE_tag;
        logic [CNT_W-1:0]                   Neighbor_num_Iter;
    } Neighbor_bank_CNTL2Edge_PE;

    typedef struct packed {
        logic             last;
        logic [NID_W-1:0] nid;
    } nid_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

endpackage

// File: rtl/nid_fifo2w.sv
// Dual-push / single-pop FIFO of neighbor-ID entries; caller guarantees no overflow/underflow.
module nid_fifo2w
    import neighbor_stream_rx_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push0,
    input  logic                     push1,
    input  nid_entry_t               din0,
    input  nid_entry_t               din1,
    input  logic                     pop,
    output nid_entry_t               head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    nid_entry_t      mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;

    // push1 is only ever asserted together with push0, so din1 lands right after din0
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push0) mem[wr_ptr] <= din0;
            if (push1) mem[wr_ptr + AW'(1)] <= din1;
            wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + CW'(push0) + CW'(push1) - CW'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/neighbor_stream_rx.sv
// Edge-PE neighbor-list receiver: tag filter, two-ID beat unpack, FIFO buffering, credit export.
// Protocol error flags in err[3:0] are built only when NEIGHBOR_RX_CHECK_EN is defined.
module neighbor_stream_rx
    import neighbor_stream_rx_pkg::*;
#(
    parameter int unsigned PE_ID      = 0,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  Neighbor_bank_CNTL2Edge_PE stream_in,
    output logic                      nid_valid,
    output logic [NID_W-1:0]          nid,
    output logic                      nid_last,
    input  logic                      nid_ready,
    output logic                      rx_credit,
    output logic                      pkt_done,
    output logic [3:0]                err
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    rx_state_e        state;
    logic [CNT_W-1:0] rem;
    logic [CW-1:0]    count;
    nid_entry_t       head;
    nid_entry_t       din0;
    nid_entry_t       din1;
    logic             acc;
    logic             start;
    logic             cont;
    logic             close;
    logic             fits;
    logic             push0;
    logic             push1;
    logic             pop;
    logic [CNT_W-1:0] n_eff;
    logic [CNT_W-1:0] avail;
    logic [CNT_W-1:0] rem_nxt;
    logic [1:0]       n_ids;

    // Beat classification and unpack; a sos beat always (re)starts a list
    always_comb begin
        acc     = stream_in.valid && (stream_in.PE_tag == TAG_W'(PE_ID));
        start   = acc && stream_in.sos;
        cont    = acc && !stream_in.sos && (state == RECV);
        n_eff   = (stream_in.Neighbor_num_Iter == '0) ? CNT_W'(1) : stream_in.Neighbor_num_Iter;
        avail   = start ? n_eff : rem;
        n_ids   = 2'd0;
        if (start || cont)
            n_ids = (avail >= CNT_W'(2)) ? 2'd2 : avail[1:0];
        rem_nxt = avail - CNT_W'(n_ids);
        close   = (start || cont) && stream_in.eos;
        fits    = (32'(count) + 32'(n_ids)) <= FIFO_DEPTH;
        push0   = (n_ids != 2'd0) && fits;
        push1   = (n_ids == 2'd2) && fits;
        din0    = '{last: close && (n_ids == 2'd1), nid: stream_in.FV_data[NID_W-1:0]};
        din1    = '{last: close, nid: stream_in.FV_data[2*NID_W-1:NID_W]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rem      <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= close;
            if (start || cont) begin
                state <= stream_in.eos ? IDLE : RECV;
                rem   <= stream_in.eos ? '0 : rem_nxt;
            end
        end
    end

    nid_fifo2w #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push0 (push0),
        .push1 (push1),
        .din0  (din0),
        .din1  (din1),
        .pop   (pop),
        .head  (head),
        .count (count)
    );

    assign nid_valid = (count != '0);
    assign nid       = nid_valid ? head.nid : '0;
    assign nid_last  = nid_valid && head.last;
    assign pop       = nid_valid && nid_ready;
    assign rx_credit = (FIFO_DEPTH - 32'(count)) >= max_degree_Iter;

`ifdef NEIGHBOR_RX_CHECK_EN
    logic orphan;
    logic len_err;

    // Length error: eos that does not exactly exhaust the list, or list exhausted before eos
    assign orphan  = acc && !stream_in.sos && (state == IDLE);
    assign len_err = (start || cont) &&
                     (stream_in.eos ? ((rem_nxt != '0) || (n_ids == 2'd0)) : (rem_nxt == '0));

    always_ff @(posedge clk) begin
        if (reset)
            err <= '0;
        else
            err <= err | {len_err, start && (state == RECV), orphan, (n_ids != 2'd0) && !fits};
    end
`else
    assign err = 4'd0;
`endif

endmodule

// File: tb/tb_neighbor_stream_rx.sv
// Scoreboard bench for neighbor_stream_rx: directed lists, expected IDs queued at issue time.
`timescale 1ns/1ps
module tb_neighbor_stream_rx;
    import neighbor_stream_rx_pkg::*;

`ifdef NEIGHBOR_RX_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset;
    Neighbor_bank_CNTL2Edge_PE stream_in;
    logic                      nid_valid;
    logic [NID_W-1:0]          nid;
    logic                      nid_last;
    logic                      nid_ready;
    logic                      rx_credit;
    logic                      pkt_done;
    logic [3:0]                err;

    int         n_assert = 0;
    int         n_fail   = 0;
    int         exp_pkt  = 0;
    int         pkt_cnt  = 0;
    nid_entry_t exp_q[$];
    nid_entry_t mon_e;

    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic             prev_last  = 1'b0;
    logic [NID_W-1:0] prev_nid   = '0;

    always #5 clk = ~clk;

    neighbor_stream_rx #(
        .PE_ID      (1),
        .FIFO_DEPTH (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stream_in (stream_in),
        .nid_valid (nid_valid),
        .nid       (nid),
        .nid_last  (nid_last),
        .nid_ready (nid_ready),
        .rx_credit (rx_credit),
        .pkt_done  (pkt_done),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every handshake, checks head stability and counts pkt_done
    always @(negedge clk) begin
        if (reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (prev_valid && !prev_ready)
                check("hold", 32'({nid_valid, nid_last, nid}), 32'({1'b1, prev_last, prev_nid}));
            if (pkt_done) pkt_cnt++;
            if (nid_valid && nid_ready) begin
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $display("FAIL unexpected_nid: got nid 0x%0h last %0b, expected none", nid, nid_last);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("nid", 32'(nid), 32'(mon_e.nid));
                    check("nid_last", 32'(nid_last), 32'(mon_e.last));
                end
            end
            prev_valid = nid_valid;
            prev_ready = nid_ready;
            prev_last  = nid_last;
            prev_nid   = nid;
        end
    end

    task automatic expect_id(input logic [NID_W-1:0] id, input logic last);
        exp_q.push_back('{last: last, nid: id});
    endtask

    task automatic beat(input logic sos, input logic eos, input logic [TAG_W-1:0] tag,
                        input logic [CNT_W-1:0] n, input logic [15:0] data);
        stream_in.valid             = 1'b1;
        stream_in.sos               = sos;
        stream_in.eos               = eos;
        stream_in.PE_tag            = tag;
        stream_in.Neighbor_num_Iter = n;
        stream_in.FV_data           = data;
        @(posedge clk); #1;
        stream_in = '0;
    endtask

    task automatic drain(input string name);
        int cyc;
        cyc = 0;
        nid_ready = 1'b1;
        @(posedge clk); #1;
        while ((exp_q.size() != 0 || nid_valid) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({name, "_pkt"}, 32'(pkt_cnt), 32'(exp_pkt));
    endtask

    task automatic check_reset(input string name);
        check({name, "_valid"}, 32'(nid_valid), 32'd0);
        check({name, "_nid"}, 32'(nid), 32'd0);
        check({name, "_last"}, 32'(nid_last), 32'd0);
        check({name, "_credit"}, 32'(rx_credit), 32'd1);
        check({name, "_pkt_done"}, 32'(pkt_done), 32'd0);
        check({name, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        repeat (2) begin @(posedge clk); #1; end
        pkt_cnt = 0;
        exp_pkt = 0;
        reset   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stream_in = '0;
        nid_ready = 1'b0;
        do_reset();
        check_reset("rst");

        // Single-beat list, N=1: upper ID discarded
        expect_id(8'h11, 1'b1);
        exp_pkt++;
        beat(1'b1, 1'b1, TAG_W'(1), CNT_W'(1), 16'h2211);
        drain("t1");

        // N=5 over three beats
        for (int i = 1; i <= 5; i++) expect_id(NID_W'(i), i == 5);
        beat(1'b1, 1'b0, TAG_W'(1), CNT_W'(5), 16'h0201);
        beat(1'b0, 1'b0, TAG_W'(1), CNT_W'(5), 16'h0403);
        beat(1'b0, 1'b1, TAG_W'(1), CNT_W'(5), 16'h0605);
        exp_pkt++;
        drain("t2");

        // Same list for another PE: ignored
        beat(1'b1, 1'b0, TAG_W'(2), CNT_W'(5), 16'h0201);
        beat(1'b0, 1'b0, TAG_W'(2), CNT_W'(5), 16'h0403);
        beat(1'b0, 1'b1, TAG_W'(2), CNT_W'(5), 16'h0605);
        drain("t3");
        check("t3_credit", 32'(rx_credit), 32'd1);

        // Fill with consumer stalled: credit drops, then overflow drops a beat
        nid_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_id(NID_W'(2*i + 1), 1'b0);
            expect_id(NID_W'(2*i + 2), i == 3);
            beat(i == 0, i == 3, TAG_W'(1), CNT_W'(8), {NID_W'(2*i + 2), NID_W'(2*i + 1)});
        end
        check("t4_credit8", 32'(rx_credit), 32'd1);
        for (int i = 0; i < 3; i++) begin
            expect_id(NID_W'(8'h21 + 2*i), 1'b0);
            expect_id(NID_W'(8'h22 + 2*i), i == 2);
            beat(i == 0, i == 2, TAG_W'(1), CNT_W'(6), {NID_W'(8'h22 + 2*i), NID_W'(8'h21 + 2*i)});
        end
        check("t4_credit14", 32'(rx_credit), 32'd0);
        expect_id(8'h31, 1'b0);
        expect_id(8'h32, 1'b0);
        beat(1'b1, 1'b0, TAG_W'(1), CNT_W'(3), 16'h3231);
        beat(1'b0, 1'b1, TAG_W'(1), CNT_W'(3), 16'h3433);
        exp_pkt += 3;
        check("t4_err", 32'(err), 32'({3'b000, CHK}));
        drain("t4");
        check("t4_credit_after", 32'(rx_credit), 32'd1);
        do_reset();

        // Orphan non-sos beat in IDLE
        beat(1'b0, 1'b1, TAG_W'(1), CNT_W'(2), 16'h5251);
        drain("t5");
        check("t5_err", 32'(err), 32'({2'b00, CHK, 1'b0}));
        do_reset();

        // sos in the middle of a list restarts it
        expect_id(8'h01, 1'b0);
        expect_id(8'h02, 1'b0);
        beat(1'b1, 1'b0, TAG_W'(1), CNT_W'(6), 16'h0201);
        expect_id(8'h0A, 1'b0);
        expect_id(8'h0B, 1'b0);
        beat(1'b1, 1'b0, TAG_W'(1), CNT_W'(3), 16'h0B0A);
        expect_id(8'h0C, 1'b1);
        beat(1'b0, 1'b1, TAG_W'(1), CNT_W'(3), 16'h0D0C);
        exp_pkt++;
        drain("t6");
        check("t6_err", 32'(err), 32'({1'b0, CHK, 2'b00}));
        do_reset();

        // Reset mid-list: outputs clear, continuation beat becomes an orphan
        nid_ready = 1'b0;
        beat(1'b1, 1'b0, TAG_W'(1), CNT_W'(6), 16'h0201);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check_reset("t7");
        reset   = 1'b0;
        pkt_cnt = 0;
        exp_pkt = 0;
        beat(1'b0, 1'b1, TAG_W'(1), CNT_W'(6), 16'h0403);
        drain("t7");
        check("t7_err", 32'(err), 32'({2'b00, CHK, 1'b0}));
        do_reset();

        // N=4 list whose eos arrives on a third beat
        for (int i = 1; i <= 4; i++) expect_id(NID_W'(i), 1'b0);
        beat(1'b1, 1'b0, TAG_W'(1), CNT_W'(4), 16'h0201);
        beat(1'b0, 1'b0, TAG_W'(1), CNT_W'(4), 16'h0403);
        beat(1'b0, 1'b1, TAG_W'(1), CNT_W'(4), 16'h0605);
        exp_pkt++;
        drain("t8");
        check("t8_err", 32'(err), 32'({CHK, 3'b000}));
        do_reset();

        // N=0 behaves as N=1; N=2 single beat delivers both IDs
        expect_id(8'h33, 1'b1);
        beat(1'b1, 1'b1, TAG_W'(1), CNT_W'(0), 16'h3433);
        expect_id(8'h41, 1'b0);
        expect_id(8'h42, 1'b1);
        beat(1'b1, 1'b1, TAG_W'(1), CNT_W'(2), 16'h4241);
        exp_pkt += 2;
        drain("t9");
        check("t9_err", 32'(err), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
